ahb_mem_ctrl: RTL
=================

Name: ahb_mem_ctrl

Overview:
- Memory-side stage directly downstream of the AHB slave interface.
- Consumes the slave's valid / rd0_wr1 / addr / wr_data request and returns ready / rd_valid / rd_data.
- Owns a word-organised on-chip storage array with parameterisable read and write wait states, which exercises the slave's hreadyout stall path.
- o_ready is decoded from registered state only, so there is no combinational path from request inputs.

Parameters:
- DATA_WIDTH, 32, data bus and storage word width.
- ADDR, 32, request address width (byte address).
- DEPTH, 256, number of storage words; power of two, ≥ 2.
- RD_LAT, 2, busy cycles between read acceptance and the read response cycle; legal range 1..15.
- WR_LAT, 1, busy cycles after write acceptance; legal range 0..15.

Ports:
- i_clk_ahb  in  1  clock.
- i_rstn_ahb  in  1  reset, asynchronous, active-low.
- i_valid  in  1  request valid from the AHB slave.
- i_rd0_wr1  in  1  request direction: 0 = read, 1 = write.
- i_addr  in  ADDR  byte address; bits [1:0] are ignored.
- i_wr_data  in  DATA_WIDTH  write data.
- o_ready  out  1  controller can accept a request, or is presenting a read response.
- o_rd_valid  out  1  read data valid, one-cycle pulse.
- o_rd_data  out  DATA_WIDTH  read data.
- o_err  out  1  out-of-range access flag, one-cycle pulse.

Behaviour:
- Reset values (asynchronous): state=IDLE, o_ready=1, o_rd_valid=0, o_rd_data=0, o_err=0, busy counter=0, all storage words=0.
- Reset asserted mid-operation aborts the transaction: no write commit, no response.
- Address decode: word index = i_addr[log2(DEPTH)+1:2].
  - Out-of-range when i_addr ≥ DEPTH*4.
  - Out-of-range write: dropped.
  - Out-of-range read: returns 0.
  - Both raise o_err.
- Acceptance: a request is accepted on a rising edge where i_valid=1 and state ∈ {IDLE, RD_RESP}. The controller captures direction, word index, wr_data and the range flag.
- i_valid while BUSY is ignored and not queued; the source must hold the request until o_ready=1.
- FSM states: IDLE, WR_BUSY, RD_BUSY, RD_RESP.
  - IDLE: o_ready=1.
    - Read accepted → RD_BUSY; counter loads RD_LAT-1.
    - Write accepted → storage committed on the same edge. If WR_LAT=0, stay IDLE; else → WR_BUSY with counter loaded to WR_LAT-1.
  - WR_BUSY: o_ready=0. Counter decrements each cycle; at 0 → IDLE.
  - RD_BUSY: o_ready=0. Counter decrements each cycle; at 0 → RD_RESP, loading o_rd_data from storage (0 if out-of-range).
  - RD_RESP (exactly one cycle): o_ready=1, o_rd_valid=1. A request accepted here follows the same transitions as in IDLE (back-to-back). Otherwise → IDLE.
- Latency, cycle 0 = accept edge:
  - Read: o_ready=0 in cycles 1..RD_LAT; o_rd_valid=1 with data in cycle RD_LAT+1.
  - Write: o_ready=0 in cycles 1..WR_LAT.
- o_rd_data holds its last read value outside RD_RESP. o_rd_valid is never asserted for writes.
- o_err timing:
  - Reads: asserted in the RD_RESP cycle.
  - Writes: asserted in cycle 1 after acceptance.
- Read-after-write to the same address returns the new data, because writes commit at acceptance.
- o_ready, o_rd_valid and o_err are decoded only from registers.

Decomposition:
- Package ahb_mem_pkg holds:
  - state enum (IDLE, WR_BUSY, RD_BUSY, RD_RESP), 2-bit encoding;
  - localparam for counter width (4);
  - function computing the word-index width from DEPTH.
- One sub-module, ahb_mem_array:
  - DEPTH×DATA_WIDTH storage with async clear;
  - synchronous write port (we, widx, wdata);
  - combinational read port (ridx → rdata).
- The controller registers the array's read output into o_rd_data.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10, then read 0x10 (RD_LAT=2, WR_LAT=1) → o_ready low exactly 1 cycle after the write. On the read, o_ready is low 2 cycles, then o_rd_valid=1 with o_rd_data=0xDEADBEEF in cycle 3.
- Back-to-back: hold i_valid with reads of 0x0 then 0x4 after writing 0x11111111 / 0x22222222 → second read accepted in the RD_RESP cycle of the first. Responses 0x11111111 then 0x22222222, 3 cycles apart.
- WR_LAT=0: four consecutive writes to 0x0, 0x4, 0x8, 0xC → o_ready stays 1 throughout. Readback returns all four values.
- Out-of-range: write 0xCAFEF00D to 0x400 (DEPTH=256), then read 0x400 → o_err pulse in cycle 1 after the write. Read gives o_rd_data=0 with o_err=1 in RD_RESP; word 0 is still unchanged.
- Busy ignore: change i_addr from 0x20 to 0x24 during RD_BUSY → response is word 0x20's data. 0x24 is accepted only after the source re-presents it when o_ready=1.
- Reset mid-read: assert i_rstn_ahb during RD_BUSY → o_rd_valid never pulses, o_ready=1 immediately, a subsequent read of any address returns 0.

Source files
------------

// File: rtl/ahb_mem_pkg.sv
// Shared types and helpers for the AHB memory-side controller and its storage array.
package ahb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    RD_RESP = 2'd3
  } state_t;

  localparam int CNT_W = 4;

  // Word-index width; a single-word array still needs a 1-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised storage: asynchronous clear, synchronous write, combinational read.
module ahb_mem_array
  import ahb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IW         = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IW-1:0]         ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_mem_ctrl.sv
// Memory-side stage behind the AHB slave: accepts read/write requests, applies
// configurable wait states and returns registered read data and error pulses.
module ahb_mem_ctrl
  import ahb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR       = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR-1:0]       i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_err
);

  localparam int IW = idx_width(DEPTH);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = (WR_LAT > 0) ? CNT_W'(WR_LAT - 1) : '0;
  localparam logic [ADDR-1:0]  LIMIT   = ADDR'(DEPTH * 4);

  // Handshake: a request transfers on a rising edge where i_valid=1 and
  // o_ready=1; o_ready depends only on the state register, so the source
  // must hold the request until it sees o_ready=1.

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IW-1:0]         rd_idx;
  logic                  rd_oor;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  err_q, err_nxt;
  logic                  accept, load_rd, wr_en, in_oor;
  logic [IW-1:0]         in_idx;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign in_idx = i_addr[IW+1:2];
  assign in_oor = (i_addr >= LIMIT);
  assign accept = i_valid && ((state == IDLE) || (state == RD_RESP));
  // Writes commit on the accept edge, so a following read sees new data.
  assign wr_en  = accept && i_rd0_wr1 && !in_oor;

  ahb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IW         (IW)
  ) u_array (
    .clk   (i_clk_ahb),
    .rst_n (i_rstn_ahb),
    .we    (wr_en),
    .widx  (in_idx),
    .wdata (i_wr_data),
    .ridx  (rd_idx),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    load_rd   = 1'b0;
    case (state)
      IDLE, RD_RESP: begin
        state_nxt = IDLE;
        if (accept) begin
          if (i_rd0_wr1) begin
            err_nxt = in_oor;
            if (WR_LAT > 0) begin
              state_nxt = WR_BUSY;
              cnt_nxt   = WR_LOAD;
            end
          end else begin
            state_nxt = RD_BUSY;
            cnt_nxt   = RD_LOAD;
          end
        end
      end
      WR_BUSY: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RD_BUSY: begin
        if (cnt == '0) begin
          state_nxt = RD_RESP;
          load_rd   = 1'b1;
          err_nxt   = rd_oor;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_idx    <= '0;
      rd_oor    <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      if (accept) begin
        rd_idx <= in_idx;
        rd_oor <= in_oor;
      end
      if (load_rd) rd_data_q <= rd_oor ? '0 : arr_rdata;
    end
  end

  assign o_ready    = (state == IDLE) || (state == RD_RESP);
  assign o_rd_valid = (state == RD_RESP);
  assign o_rd_data  = rd_data_q;
  assign o_err      = err_q;

endmodule
